// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared constants and helpers for the programmable clock divider
package clk_div_pkg;

  localparam int unsigned DIV_MIN = 2;

  function automatic int unsigned half_ceil(input int unsigned n);
    return (n + 1) >> 1;
  endfunction

  function automatic int unsigned coerce_div(input int unsigned n);
    return (n < DIV_MIN) ? DIV_MIN : n;
  endfunction

endpackage

// File: rtl/clk_div_if.sv
// rtl/clk_div_if.sv - control/status bundle between a rate client and the divider
interface clk_div_if #(
  parameter int WIDTH = 8
) ();
  logic             en;
  logic             load;
  logic [WIDTH-1:0] div;
  logic             O;
  logic             tick;
  logic             err;
  logic [WIDTH-1:0] div_act;

  modport master (output en, load, div, input O, tick, err, div_act);
  modport slave  (input en, load, div, output O, tick, err, div_act);
endinterface

// File: rtl/clk_div_ctr.sv
// rtl/clk_div_ctr.sv - mod-N phase counter with registered divided clock and period tick
module clk_div_ctr
  import clk_div_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             I,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] div_act,
  output logic             O,
  output logic             tick,
  output logic             wrap
);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] high_len;

  assign high_len = WIDTH'(half_ceil(32'(div_act)));
  assign wrap     = (cnt == (div_act - WIDTH'(1)));

  always_ff @(posedge I or negedge rst) begin
    if (!rst) begin
      cnt  <= '0;
      O    <= 1'b0;
      tick <= 1'b0;
    end else if (en) begin
      O    <= (cnt < high_len);
      tick <= (cnt == '0);
      cnt  <= wrap ? '0 : cnt + WIDTH'(1);
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/clk_div_n.sv
// rtl/clk_div_n.sv - runtime-programmable divide-by-N with boundary-aligned divisor changes
module clk_div_n
  import clk_div_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 2
) (
  input  logic     I,
  input  logic     rst,
  clk_div_if.slave bus
);

  logic [WIDTH-1:0] div_act_r;
  logic [WIDTH-1:0] pend_div;
  logic             pend_valid;
  logic             err_r;
  logic             wrap;
  logic             boundary;
  logic [WIDTH-1:0] load_div;

  assign load_div = WIDTH'(coerce_div(32'(bus.div)));
  assign boundary = bus.en && wrap;

  clk_div_ctr #(.WIDTH(WIDTH)) u_ctr (
    .I       (I),
    .rst     (rst),
    .en      (bus.en),
    .div_act (div_act_r),
    .O       (bus.O),
    .tick    (bus.tick),
    .wrap    (wrap)
  );

  // A load landing on the boundary edge itself bypasses the pending slot.
  always_ff @(posedge I or negedge rst) begin
    if (!rst) begin
      div_act_r  <= WIDTH'(DEFAULT_DIV);
      pend_div   <= '0;
      pend_valid <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      err_r <= bus.load && (bus.div < WIDTH'(DIV_MIN));
      if (boundary) begin
        if (bus.load)
          div_act_r <= load_div;
        else if (pend_valid)
          div_act_r <= pend_div;
        pend_valid <= 1'b0;
      end else if (bus.load) begin
        pend_div   <= load_div;
        pend_valid <= 1'b1;
      end
    end
  end

  assign bus.div_act = div_act_r;
  assign bus.err     = err_r;

endmodule

// File: tb/tb_clk_div_n.sv
// tb/tb_clk_div_n.sv - randomized self-checking bench for clk_div_n against a waveform-queue model
module tb_clk_div_n;

  logic I = 1'b0;
  logic rst = 1'b0;
  clk_div_if #(.WIDTH(8)) bus ();

  clk_div_n #(.WIDTH(8), .DEFAULT_DIV(2)) dut (
    .I   (I),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 I = ~I;

  int n_chk = 0;
  int n_fail = 0;

  // Model: a queue holding the remaining {O,tick} values of the current output period.
  logic [1:0] wave_q[$];
  logic [7:0] cur;
  logic [7:0] pd;
  bit         pv;
  logic       exp_o, exp_tick, exp_err;

  function automatic logic [7:0] legal(input logic [7:0] d);
    return (d < 8'd2) ? 8'd2 : d;
  endfunction

  task automatic fill_period(input logic [7:0] n);
    for (int k = 0; k < int'(n); k++)
      wave_q.push_back({(k < (int'(n) + 1) / 2) ? 1'b1 : 1'b0, (k == 0) ? 1'b1 : 1'b0});
  endtask

  task automatic model_reset();
    wave_q.delete();
    cur = 8'd2;
    pv = 0;
    pd = 8'd0;
    exp_o = 0;
    exp_tick = 0;
    exp_err = 0;
    fill_period(cur);
  endtask

  task automatic model_edge(input bit e, input bit l, input logic [7:0] d);
    exp_err = l && (d < 8'd2);
    if (!e) begin
      exp_tick = 0;
      if (l) begin
        pv = 1;
        pd = legal(d);
      end
      return;
    end
    {exp_o, exp_tick} = wave_q.pop_front();
    if (wave_q.size() == 0) begin
      if (l) cur = legal(d);
      else if (pv) cur = pd;
      pv = 0;
      fill_period(cur);
    end else if (l) begin
      pv = 1;
      pd = legal(d);
    end
  endtask

  task automatic drive(input bit e, input bit l, input logic [7:0] d);
    bus.en = e;
    bus.load = l;
    bus.div = d;
    @(posedge I);
    #1;
    model_edge(e, l, d);
  endtask

  task automatic test_reset();
    bus.en = 1;
    bus.load = 0;
    bus.div = 8'd0;
    model_reset();
    repeat (3) @(posedge I);
    #1;
    n_chk++;
    if ({bus.O, bus.tick, bus.err, bus.div_act} !== {1'b0, 1'b0, 1'b0, 8'd2}) begin
      n_fail++;
      $display("FAIL reset_state: O/tick/err/div_act got %b/%b/%b/%0d want 0/0/0/2",
               bus.O, bus.tick, bus.err, bus.div_act);
    end
    #3 rst = 1;
  endtask

  task automatic test_default();
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, 8'd0);
      n_chk++;
      if ({bus.O, bus.tick, bus.err, bus.div_act} !== {exp_o, exp_tick, exp_err, cur}) begin
        n_fail++;
        $display("FAIL default_div2 edge %0d: got %b/%b/%b/%0d want %b/%b/%b/%0d", i,
                 bus.O, bus.tick, bus.err, bus.div_act, exp_o, exp_tick, exp_err, cur);
      end
    end
  endtask

  task automatic test_load5();
    for (int i = 0; i < 24; i++) begin
      drive(1, i == 0, 8'd5);
      n_chk++;
      if ({bus.O, bus.tick, bus.err, bus.div_act} !== {exp_o, exp_tick, exp_err, cur}) begin
        n_fail++;
        $display("FAIL load5 edge %0d: got %b/%b/%b/%0d want %b/%b/%b/%0d", i,
                 bus.O, bus.tick, bus.err, bus.div_act, exp_o, exp_tick, exp_err, cur);
      end
    end
    // Load placed exactly on the boundary edge must take effect at that same boundary.
    for (int i = 0; i < 12; i++) begin
      drive(1, wave_q.size() == 1 && i > 0, 8'd3);
      n_chk++;
      if ({bus.O, bus.tick, bus.err, bus.div_act} !== {exp_o, exp_tick, exp_err, cur}) begin
        n_fail++;
        $display("FAIL boundary_load edge %0d: got %b/%b/%b/%0d want %b/%b/%b/%0d", i,
                 bus.O, bus.tick, bus.err, bus.div_act, exp_o, exp_tick, exp_err, cur);
      end
    end
  endtask

  task automatic test_last_wins();
    int guard;
    drive(1, 1, 8'd4);
    guard = 0;
    while (!(cur == 8'd4 && wave_q.size() == 3) && guard < 40) begin
      drive(1, 0, 8'd0);
      guard++;
    end
    n_chk++;
    if (bus.div_act !== 8'd4) begin
      n_fail++;
      $display("FAIL last_wins_setup: div_act got %0d want 4", bus.div_act);
    end
    drive(1, 1, 8'd7);
    drive(1, 1, 8'd3);
    for (int i = 0; i < 16; i++) begin
      drive(1, 0, 8'd0);
      n_chk++;
      if ({bus.O, bus.tick, bus.err, bus.div_act} !== {exp_o, exp_tick, exp_err, cur} ||
          bus.div_act == 8'd7) begin
        n_fail++;
        $display("FAIL last_wins edge %0d: got %b/%b/%b/%0d want %b/%b/%b/%0d", i,
                 bus.O, bus.tick, bus.err, bus.div_act, exp_o, exp_tick, exp_err, cur);
      end
    end
  endtask

  task automatic test_illegal();
    drive(1, 1, 8'd0);
    n_chk++;
    if (bus.err !== 1'b1) begin
      n_fail++;
      $display("FAIL illegal_err_pulse: err got %b want 1", bus.err);
    end
    drive(1, 0, 8'd0);
    n_chk++;
    if (bus.err !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_err_clear: err got %b want 0", bus.err);
    end
    for (int i = 0; i < 10; i++) begin
      drive(1, i == 4, 8'd1);
      n_chk++;
      if ({bus.O, bus.tick, bus.err, bus.div_act} !== {exp_o, exp_tick, exp_err, cur}) begin
        n_fail++;
        $display("FAIL illegal edge %0d: got %b/%b/%b/%0d want %b/%b/%b/%0d", i,
                 bus.O, bus.tick, bus.err, bus.div_act, exp_o, exp_tick, exp_err, cur);
      end
    end
  endtask

  task automatic test_en_gap();
    int guard;
    int edges;
    drive(1, 1, 8'd6);
    guard = 0;
    while (!(cur == 8'd6 && wave_q.size() == 4) && guard < 40) begin
      drive(1, 0, 8'd0);
      guard++;
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 8'd0);
      n_chk++;
      if ({bus.O, bus.tick, bus.err, bus.div_act} !== {exp_o, 1'b0, exp_err, 8'd6}) begin
        n_fail++;
        $display("FAIL en_gap_hold %0d: got %b/%b/%b/%0d want %b/0/%b/6", i,
                 bus.O, bus.tick, bus.err, bus.div_act, exp_o, exp_err);
      end
    end
    edges = 0;
    guard = 0;
    do begin
      drive(1, 0, 8'd0);
      edges++;
      n_chk++;
      if ({bus.O, bus.tick, bus.err, bus.div_act} !== {exp_o, exp_tick, exp_err, cur}) begin
        n_fail++;
        $display("FAIL en_gap_resume edge %0d: got %b/%b/%b/%0d want %b/%b/%b/%0d", edges,
                 bus.O, bus.tick, bus.err, bus.div_act, exp_o, exp_tick, exp_err, cur);
      end
    end while (bus.tick !== 1'b1 && edges < 20);
    n_chk++;
    if (edges != 5) begin
      n_fail++;
      $display("FAIL en_gap_period: edges to next tick got %0d want 5", edges);
    end
  endtask

  task automatic test_random();
    bit e, l;
    logic [7:0] d;
    for (int i = 0; i < 400; i++) begin
      e = ($urandom_range(0, 4) != 0);
      l = ($urandom_range(0, 7) == 0);
      d = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 1)) : 8'($urandom_range(2, 12));
      drive(e, l, d);
      n_chk++;
      if ({bus.O, bus.tick, bus.err, bus.div_act} !== {exp_o, exp_tick, exp_err, cur}) begin
        n_fail++;
        $display("FAIL random edge %0d: got %b/%b/%b/%0d want %b/%b/%b/%0d", i,
                 bus.O, bus.tick, bus.err, bus.div_act, exp_o, exp_tick, exp_err, cur);
      end
    end
  endtask

  task automatic test_async_reset();
    drive(1, 1, 8'd9);
    repeat (6) drive(1, 0, 8'd0);
    #2 rst = 0;
    #1;
    n_chk++;
    if ({bus.O, bus.tick, bus.err, bus.div_act} !== {1'b0, 1'b0, 1'b0, 8'd2}) begin
      n_fail++;
      $display("FAIL async_reset: got %b/%b/%b/%0d want 0/0/0/2",
               bus.O, bus.tick, bus.err, bus.div_act);
    end
    @(negedge I);
    rst = 1;
    model_reset();
    drive(1, 0, 8'd0);
    n_chk++;
    if ({bus.O, bus.tick} !== 2'b11) begin
      n_fail++;
      $display("FAIL reset_first_edge: O/tick got %b/%b want 1/1", bus.O, bus.tick);
    end
    for (int i = 0; i < 6; i++) begin
      drive(1, 0, 8'd0);
      n_chk++;
      if ({bus.O, bus.tick, bus.err, bus.div_act} !== {exp_o, exp_tick, exp_err, cur}) begin
        n_fail++;
        $display("FAIL post_reset edge %0d: got %b/%b/%b/%0d want %b/%b/%b/%0d", i,
                 bus.O, bus.tick, bus.err, bus.div_act, exp_o, exp_tick, exp_err, cur);
      end
    end
  endtask

  initial begin
    test_reset();
    test_default();
    test_load5();
    test_last_wins();
    test_illegal();
    test_en_gap();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/clk_div_n.md
Name: clk_div_n

Overview:
Parametrised, runtime-programmable clock divider that generalises the fixed divide-by-2 stage.
- Divides input clock I by any integer N ≥ 2.
- Near-50% duty: high for ceil(N/2) cycles, low for floor(N/2) cycles.
- Provides a one-cycle period-start tick, a clock enable, and glitch-free divisor changes that take effect only at period boundaries.
- Sits in the lab clocking chain, feeding counters and display logic that need slower or selectable rates.

Parameters:
- WIDTH, 8, width of the divisor, counter and active-divisor bus.
- DEFAULT_DIV, 2, divisor loaded at reset; must be ≥ 2 and < 2^WIDTH.

Ports:
- I  input  1  input clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset).
- en  input  1  count enable; when 0, all state holds.
- div  input  WIDTH  requested divisor, sampled only when load=1.
- load  input  1  one-cycle request to adopt div at the next period boundary.
- O  output  1  divided clock, registered.
- tick  output  1  one-cycle pulse on the I cycle in which O rises.
- div_act  output  WIDTH  divisor currently in effect.
- err  output  1  one-cycle pulse: the loaded div was < 2 and was coerced.

Behaviour:
- Reset (rst=0, asynchronous, any time): cnt=0, O=0, tick=0, err=0, div_act=DEFAULT_DIV, pending cleared. No partial period survives reset.
- Let H = ceil(div_act/2), computed as (div_act+1)>>1.
- Each rising edge with en=1:
  - O <= (cnt < H).
  - tick <= (cnt == 0).
  - cnt <= (cnt == div_act-1) ? 0 : cnt+1.
- Each rising edge with en=0: cnt, O, div_act and pending hold; tick <= 0.
- Latency: first enabled edge after reset gives O=1 and tick=1 together. O period is exactly div_act enabled cycles.
- Load handling:
  - load=1 captures div into the pending register; a later load before the boundary overwrites it (last wins).
  - Boundary = enabled edge with cnt == div_act-1. At the boundary, div_act <= pending and pending clears.
  - load on the boundary cycle itself: that div applies at this boundary (bypasses pending).
  - load while en=0: captured; applies at the next enabled boundary.
- Illegal divisor: div < 2 on load is coerced to 2. err <= 1 on the edge after load; it does not wait for the boundary.
- Width rule: cnt is WIDTH bits and never exceeds div_act-1. Maximum divisor is 2^WIDTH-1.
- Outputs are free of glitches at divisor change: every phase completes its old length before the new divisor applies.

Decomposition:
- Package clk_div_pkg:
  - DIV_MIN = 2.
  - Function half_ceil(n) returning (n+1)>>1.
  - Function coerce_div(n) returning max(n, DIV_MIN).
- One sub-module, clk_div_ctr: the mod-N counter with wrap flag and the O/tick compare, parametrised by WIDTH.
- Top level keeps the pending/load logic, div_act and err.
- O is the registered output of the existing d_flip_flop style stage, or an equivalent flop; it is never driven combinationally.

Test Plan:
- Reset then en=1, no load → O = 1,0,1,0…, tick on every other cycle, div_act=2.
- load div=5 at cycle 0, en=1 → after the current period completes, O = 1,1,1,0,0 repeating; tick every 5 cycles; div_act=5 from the boundary edge.
- div=4 active; load div=7 at cnt=1, then load div=3 at cnt=2 → the current period finishes with 4 cycles, then period 3 (O=1,1,0); 7 is never used.
- load div=0 → err pulses high for exactly one cycle on the next edge; div_act becomes 2 at the boundary; O toggles every cycle.
- div=6, en dropped for 4 cycles at cnt=2 → O and cnt frozen, tick=0; on resume the remaining 4 cycles of the period complete, so the total enabled period is still 6.
- rst pulsed low asynchronously mid-period (between edges) → O, tick, err = 0 immediately; div_act=DEFAULT_DIV; after release, the first enabled edge gives O=1 and tick=1.
